// File: rtl/wb2axi_pkg.sv
// Shared types and AXI encodings for the Wishbone-to-AXI4 master bridge.
package wb2axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/wb2axi_master.sv
// Wishbone-classic slave to single-beat AXI4 master (64-bit data), one transaction in flight.
// Define WB2AXI_ERR_EN to turn non-OKAY AXI responses into o_wb_err pulses.
module wb2axi_master
  import wb2axi_pkg::*;
#(
  parameter int unsigned          AW       = 32,
  parameter int unsigned          ID_WIDTH = 1,
  parameter logic [ID_WIDTH-1:0]  AXI_ID   = '0
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [AW-1:2]       i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic                o_wb_err,

  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,

  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,

  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,

  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,

  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        ack_q, err_q;
  logic [31:0] rdt_q;
  logic        drop_q;

  logic [31:0] wb_byte_adr;
  logic        aw_pend, w_pend;
  logic        wb_live;
  logic        b_err, r_err;
  logic [31:0] rd_lane;

  assign wb_byte_adr = 32'({i_wb_adr, 2'b00});

  always_comb begin
    aw_pend = awvalid_q & ~i_awready;
    w_pend  = wvalid_q & ~i_wready;
    // A master that dropped cyc must never see the completion of its abandoned access.
    wb_live = ~drop_q & i_wb_cyc;
    rd_lane = addr_q[2] ? i_rdata[63:32] : i_rdata[31:0];
  end

`ifdef WB2AXI_ERR_EN
  assign b_err    = (i_bresp != AXI_RESP_OKAY);
  assign r_err    = (i_rresp != AXI_RESP_OKAY);
  assign o_wb_err = err_q;
  logic unused_sigs;
  assign unused_sigs = ^{i_bid, i_rid, i_rlast};
`else
  assign b_err    = 1'b0;
  assign r_err    = 1'b0;
  assign o_wb_err = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{i_bid, i_rid, i_rlast, i_bresp, i_rresp, err_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdt_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q != StIdle && !i_wb_cyc) drop_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          // Completion-pulse cycle still shows the old stb; ignoring it prevents a double issue.
          if (i_wb_cyc && i_wb_stb && !ack_q && !err_q) begin
            addr_q  <= wb_byte_adr;
            wdata_q <= {i_wb_dat, i_wb_dat};
            wstrb_q <= i_wb_adr[2] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
            drop_q  <= 1'b0;
            if (i_wb_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWaddr;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRaddr;
            end
          end
        end
        StWaddr: begin
          awvalid_q <= aw_pend;
          wvalid_q  <= w_pend;
          if (!aw_pend && !w_pend) begin
            bready_q <= 1'b1;
            state_q  <= StWresp;
          end
        end
        StWresp: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            ack_q    <= wb_live & ~b_err;
            err_q    <= wb_live & b_err;
            state_q  <= StIdle;
          end
        end
        StRaddr: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (i_rvalid) begin
            rready_q <= 1'b0;
            rdt_q    <= r_err ? 32'h0 : rd_lane;
            ack_q    <= wb_live & ~r_err;
            err_q    <= wb_live & r_err;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_wb_rdt  = rdt_q;
  assign o_wb_ack  = ack_q;

  assign o_awid    = AXI_ID;
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'd0;
  assign o_awsize  = AXI_SIZE_4B;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awvalid = awvalid_q;

  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = wvalid_q;

  assign o_bready  = bready_q;

  assign o_arid    = AXI_ID;
  assign o_araddr  = addr_q;
  assign o_arlen   = 8'd0;
  assign o_arsize  = AXI_SIZE_4B;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arvalid = arvalid_q;

  assign o_rready  = rready_q;

endmodule

// File: tb/tb_wb2axi_master.sv
// Directed bench for wb2axi_master: a delay-programmable AXI slave plus queue-based scoreboard.
module tb_wb2axi_master;
  import wb2axi_pkg::*;

  localparam int unsigned AW   = 32;
  localparam logic [0:0]  TbId = 1'b1;
`ifdef WB2AXI_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  typedef struct packed {
    logic        is_err;
    logic [31:0] rdt;
    logic        is_read;
  } resp_t;

  logic clk, rst_n;
  logic [AW-1:2] i_wb_adr;
  logic [31:0] i_wb_dat, o_wb_rdt;
  logic [3:0]  i_wb_sel;
  logic i_wb_we, i_wb_cyc, i_wb_stb, o_wb_ack, o_wb_err;
  logic [0:0]  o_awid, o_arid, i_bid, i_rid;
  logic [31:0] o_awaddr, o_araddr;
  logic [7:0]  o_awlen, o_arlen, o_wstrb;
  logic [2:0]  o_awsize, o_arsize;
  logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
  logic o_awvalid, i_awready, o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
  logic o_arvalid, i_arready, i_rlast, i_rvalid, o_rready;
  logic [63:0] o_wdata, i_rdata;

  wb2axi_master #(.AW(AW), .ID_WIDTH(1), .AXI_ID(TbId)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_wb_err(o_wb_err),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] aw_q[$];
  logic [71:0] w_q[$];
  logic [31:0] ar_q[$];
  resp_t       rsp_q[$];

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_held = 0, w_held = 0, r_held = 0;
  int ack_cnt = 0;
  logic [2:0] lat1_v;
  logic [1:0] lat2_r;
  logic [1:0] last_kind;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic err);
    aw_q.push_back(a);
    w_q.push_back({d, d, (a[2] ? {s, 4'h0} : {4'h0, s})});
    rsp_q.push_back('{is_err: err, rdt: 32'h0, is_read: 1'b0});
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [63:0] rd, input logic err);
    ar_q.push_back(a);
    rsp_q.push_back('{is_err: err, rdt: (err ? 32'h0 : (a[2] ? rd[63:32] : rd[31:0])),
                      is_read: 1'b1});
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = a[AW-1:2]; i_wb_dat = d; i_wb_sel = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) lat1_v = {o_awvalid, o_wvalid, o_arvalid};
      if (lat == 2) lat2_r = {o_bready, o_rready};
    end while (!(o_wb_ack || o_wb_err) && lat < 200);
    last_kind = {o_wb_ack, o_wb_err};
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    chk("wb_complete", 64'(o_wb_ack || o_wb_err), 1);
  endtask

  // AXI slave model and monitors; everything evaluated on the falling edge.
  initial begin
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (o_awvalid) begin
        i_awready = (aw_cnt >= aw_dly);
        chk("aw_pending", 64'(aw_q.size() != 0), 1);
        if (aw_q.size() != 0) chk("awaddr", o_awaddr, aw_q[0]);
        if (i_awready) begin
          aw_held = aw_cnt + 1;
          chk("aw_const", {o_awid, o_awlen, o_awsize, o_awburst}, {TbId, 8'd0, 3'd2, 2'b01});
          if (aw_q.size() != 0) void'(aw_q.pop_front());
        end
        aw_cnt++;
      end else begin
        i_awready = 1'b0; aw_cnt = 0;
      end
      if (o_wvalid) begin
        i_wready = (w_cnt >= w_dly);
        chk("w_pending", 64'(w_q.size() != 0), 1);
        if (w_q.size() != 0) chk("wdata_wstrb", {o_wdata, o_wstrb}, w_q[0][63:0] | 64'h0);
        if (w_q.size() != 0) chk("wdata_hi", o_wdata[63:56], w_q[0][71:64]);
        chk("wlast", 64'(o_wlast), 1);
        if (i_wready) begin
          w_held = w_cnt + 1;
          if (w_q.size() != 0) void'(w_q.pop_front());
        end
        w_cnt++;
      end else begin
        i_wready = 1'b0; w_cnt = 0;
      end
      if (o_bready) begin
        i_bvalid = (b_cnt >= b_dly); b_cnt++;
      end else begin
        i_bvalid = 1'b0; b_cnt = 0;
      end
      if (o_arvalid) begin
        i_arready = (ar_cnt >= ar_dly);
        chk("ar_pending", 64'(ar_q.size() != 0), 1);
        if (ar_q.size() != 0) chk("araddr", o_araddr, ar_q[0]);
        if (i_arready) begin
          chk("ar_const", {o_arid, o_arlen, o_arsize, o_arburst}, {TbId, 8'd0, 3'd2, 2'b01});
          if (ar_q.size() != 0) void'(ar_q.pop_front());
        end
        ar_cnt++;
      end else begin
        i_arready = 1'b0; ar_cnt = 0;
      end
      if (o_rready) begin
        i_rvalid = (r_cnt >= r_dly);
        if (i_rvalid) r_held = r_cnt + 1;
        r_cnt++;
      end else begin
        i_rvalid = 1'b0; r_cnt = 0;
      end
      if (o_wb_ack || o_wb_err) begin
        resp_t e;
        ack_cnt++;
        chk("resp_pending", 64'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("resp_kind", {o_wb_ack, o_wb_err}, {~e.is_err, e.is_err});
          if (e.is_read) chk("rdt", o_wb_rdt, e.rdt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, n;
    rst_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
    i_bid = '0; i_rid = '0; i_rlast = 1'b1;
    i_bresp = 2'b00; i_rresp = 2'b00; i_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack, o_wb_err},
        7'b0);
    chk("rst_rdt", o_wb_rdt, 0);
    chk("rst_addr", o_awaddr, 0);
    chk("rst_wdata", o_wdata, 0);
    rst_n = 1'b1;

    // Zero-wait write, upper lane
    exp_write(32'h104, 32'hDEADBEEF, 4'hF, 1'b0);
    wb_xfer(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, lat);
    chk("wr_lat", lat, 3);
    chk("wr_valids_n1", lat1_v, 3'b110);
    chk("wr_bready_n2", lat2_r, 2'b10);
    // Lower lane, partial byte enables
    exp_write(32'h200, 32'h0BADF00D, 4'h3, 1'b0);
    wb_xfer(1'b1, 32'h200, 32'h0BADF00D, 4'h3, lat);

    // Reads of both lanes
    i_rdata = 64'h11223344_55667788;
    exp_read(32'h100, i_rdata, 1'b0);
    wb_xfer(1'b0, 32'h100, 32'h0, 4'hF, lat);
    chk("rd_lat", lat, 3);
    chk("rd_valids_n1", lat1_v, 3'b001);
    chk("rd_rready_n2", lat2_r, 2'b01);
    exp_read(32'h104, i_rdata, 1'b0);
    wb_xfer(1'b0, 32'h104, 32'h0, 4'hF, lat);

    // awready delayed 3 cycles, wready immediate
    aw_dly = 3;
    a0 = ack_cnt;
    exp_write(32'h208, 32'hA5A55A5A, 4'hC, 1'b0);
    wb_xfer(1'b1, 32'h208, 32'hA5A55A5A, 4'hC, lat);
    repeat (3) @(negedge clk);
    chk("aw_held", aw_held, 4);
    chk("w_held", w_held, 1);
    chk("one_ack", ack_cnt - a0, 1);
    aw_dly = 0;
    // wready delayed, awready immediate
    w_dly = 2;
    exp_write(32'h20C, 32'h12345678, 4'h1, 1'b0);
    wb_xfer(1'b1, 32'h20C, 32'h12345678, 4'h1, lat);
    chk("w_held2", w_held, 3);
    chk("aw_held2", aw_held, 1);
    w_dly = 0;

    // cyc dropped while waiting in RDATA
    r_dly = 5;
    i_rdata = 64'hCAFEF00D_87654321;
    ar_q.push_back(32'h300);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 30'(32'h300 >> 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_rready && n < 20);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    a0 = ack_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (o_rready && n < 20);
    chk("drop_rready_held", r_held, 6);
    repeat (3) @(negedge clk);
    chk("drop_no_ack", ack_cnt, a0);
    r_dly = 0;
    exp_read(32'h308, i_rdata, 1'b0);
    wb_xfer(1'b0, 32'h308, 32'h0, 4'hF, lat);
    chk("after_drop_lat", lat, 3);

    // Error responses
    i_bresp = 2'b10;
    exp_write(32'h10C, 32'hFEEDFACE, 4'hF, ErrEn);
    wb_xfer(1'b1, 32'h10C, 32'hFEEDFACE, 4'hF, lat);
    chk("bresp_kind", last_kind, ErrEn ? 2'b01 : 2'b10);
    i_bresp = 2'b00;
    i_rresp = 2'b10;
    exp_read(32'h110, i_rdata, ErrEn);
    wb_xfer(1'b0, 32'h110, 32'h0, 4'hF, lat);
    chk("rresp_kind", last_kind, ErrEn ? 2'b01 : 2'b10);
    i_rresp = 2'b00;

    // Reset while in WADDR
    aw_dly = 50; w_dly = 50;
    aw_q.push_back(32'h400);
    w_q.push_back({32'h55AA55AA, 32'h55AA55AA, 8'h0F});
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 30'(32'h400 >> 2);
    i_wb_dat = 32'h55AA55AA; i_wb_sel = 4'hF;
    repeat (2) @(negedge clk);
    chk("pre_rst_valids", {o_awvalid, o_wvalid}, 2'b11);
    rst_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack}, 6'b0);
    chk("rst_mid_state", dut.state_q, StIdle);
    rst_n = 1'b1;
    aw_q.delete(); w_q.delete();
    aw_dly = 0; w_dly = 0;
    i_rdata = 64'h0F0E0D0C_0B0A0908;
    exp_read(32'h404, i_rdata, 1'b0);
    wb_xfer(1'b0, 32'h404, 32'h0, 4'hF, lat);
    chk("post_rst_lat", lat, 3);

    repeat (3) @(negedge clk);
    chk("queues_empty", aw_q.size() + w_q.size() + ar_q.size() + rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb2axi_master.md
# wb2axi_master

Wishbone-classic slave to AXI4 master bridge. It converts single 32-bit Wishbone accesses into single-beat AXI4 transactions on a 64-bit data bus. The core's Wishbone peripheral port connects to it, so it can reach AXI-side memory such as the on-chip AXI RAM. It is the initiator counterpart of the AXI-to-Wishbone memory path and has at most one outstanding transaction.

## Interface
Parameters:
- AW, 32: Wishbone byte-address width; valid range 3..32.
- ID_WIDTH, 1: AXI ID width.
- AXI_ID, 0: constant ID driven on o_awid/o_arid.

Ports:
- clk  in  1  clock, all logic posedge.
- rst_n  in  1  reset, synchronous, active-low.
- i_wb_adr  in  AW-2  word address, bits [AW-1:2].
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables.
- i_wb_we  in  1  write enable.
- i_wb_cyc, i_wb_stb  in  1 each  cycle / strobe.
- o_wb_rdt  out  32  read data, valid with o_wb_ack.
- o_wb_ack  out  1  one-cycle completion pulse.
- o_wb_err  out  1  one-cycle error pulse (see Configuration).
- o_awid, o_arid  out  ID_WIDTH  = AXI_ID.
- o_awaddr, o_araddr  out  32  {i_wb_adr,2'b00}, zero-extended.
- o_awlen/o_arlen, o_awsize/o_arsize, o_awburst/o_arburst  out  8/3/2  constants 0, 3'd2, 2'b01 (INCR).
- o_awvalid/i_awready, o_arvalid/i_arready  out/in  1  address handshakes.
- o_wdata  out  64  {i_wb_dat,i_wb_dat}.
- o_wstrb  out  8  i_wb_sel in lane adr[2]; 0 in the other lane.
- o_wlast  out  1  constant 1.
- o_wvalid/i_wready  out/in  1  write-data handshake.
- i_bid, i_bresp, i_bvalid / o_bready  in/out  ID_WIDTH, 2, 1 / 1  write response.
- i_rid, i_rdata, i_rresp, i_rlast, i_rvalid / o_rready  in/out  ID_WIDTH, 64, 2, 1, 1 / 1  read data.

## Operation
- FSM states: IDLE, WADDR (AW+W), WRESP, RADDR, RDATA.
- IDLE: when i_wb_cyc & i_wb_stb & !o_wb_ack, register adr/dat/sel/we.
  - we=1: go to WADDR with o_awvalid=o_wvalid=1.
  - we=0: go to RADDR with o_arvalid=1.
- WADDR: each valid drops independently on its own handshake; AW and W may complete in either order or together. When both are done, go to WRESP.
- WRESP: o_bready=1. On i_bvalid, pulse ack and go to IDLE.
- RADDR: o_arvalid held until i_arready, then go to RDATA.
- RDATA: o_rready=1. On i_rvalid:
  - o_wb_rdt <= adr[2] ? i_rdata[63:32] : i_rdata[31:0].
  - Pulse ack, go to IDLE.
- All AXI outputs are registered. Payload stays stable while its valid is high.
- i_bid, i_rid and i_rlast are ignored.
- Wishbone drop (cyc falls mid-transaction): the AXI transaction still completes to protocol, and ack/err is suppressed for it.

## Timing
- Reset state: FSM IDLE.
- Reset values: every valid/ready, o_wb_ack, o_wb_err and o_wb_rdt are 0; address and data registers are 0.
- Reset mid-transaction abandons the transfer immediately. The AXI slave shares rst_n.
- Zero-wait slave, stb sampled at cycle N:
  - valids high at N+1;
  - bready/rready high at N+2;
  - earliest ack at N+3.
- Ack is registered and lasts exactly one cycle. IDLE ignores stb during the ack cycle, so there is no double issue.
- Handshake occurs when valid & ready are high at the same posedge. Holding ready low stalls indefinitely; there is no timeout.

## Configuration
- Macro WB2AXI_ERR_EN.
- Defined: i_bresp/i_rresp != 2'b00 produce an o_wb_err pulse instead of o_wb_ack, and o_wb_rdt <= 0 for an errored read.
- Undefined: o_wb_err is tied 0, responses are ignored, and every transfer acks.

## Structure
- Shared package wb2axi_pkg holds:
  - state enum;
  - AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY.
- No sub-module; lane steering and the FSM are inline.

## Test plan
- Write adr=0x104, dat=0xDEADBEEF, sel=4'hF, zero-wait slave -> awaddr=0x104, wdata=0xDEADBEEF_DEADBEEF, wstrb=8'hF0, ack at N+3.
- Read adr=0x100, slave rdata=0x11223344_55667788 -> o_wb_rdt=0x55667788; adr=0x104 -> 0x11223344.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, payload stable, exactly one ack.
- cyc dropped during RDATA with rvalid delayed 5 cycles -> rready stays until the handshake, no ack, next access proceeds normally.
- With WB2AXI_ERR_EN, bresp=2'b10 -> o_wb_err pulse, o_wb_ack stays 0. Without it, the same stimulus -> ack.
- rst_n low while in WADDR -> next cycle all valids 0 and FSM IDLE, and a fresh read completes.
